// File: rtl/hit_resolver.sv
// Frame-rate hit sequencer: samples both collision checkers once per frame,
// enforces one connection per attack, resolves trades and runs victim stun timers.
module hit_resolver #(
  parameter int HITSTUN_FRAMES   = 20,
  parameter int BLOCKSTUN_FRAMES = 12,
  parameter int CNT_W            = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             attack_start_p1,
  input  logic             attack_start_p2,
  input  logic             got_hit_p1,
  input  logic             got_blocked_p1,
  input  logic             got_hit_p2,
  input  logic             got_blocked_p2,
  output logic             hitbox_enable_p1,
  output logic             hitbox_enable_p2,
  output logic             hit_evt_p1,
  output logic             block_evt_p1,
  output logic             hit_evt_p2,
  output logic             block_evt_p2,
  output logic             trade_evt,
  output logic             in_hitstun_p1,
  output logic             in_blockstun_p1,
  output logic             in_hitstun_p2,
  output logic             in_blockstun_p2,
  output logic [CNT_W-1:0] stun_cnt_p1,
  output logic [CNT_W-1:0] stun_cnt_p2
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HITSTUN   = 2'd1,
    BLOCKSTUN = 2'd2
  } vstate_t;

  typedef struct packed {
    vstate_t          st;
    logic [CNT_W-1:0] cnt;
  } victim_t;

  localparam logic [CNT_W-1:0] HIT_LD = CNT_W'(HITSTUN_FRAMES);
  localparam logic [CNT_W-1:0] BLK_LD = CNT_W'(BLOCKSTUN_FRAMES);

  logic    armed_p1, armed_p2;
  logic    armed_eff_p1, armed_eff_p2;
  logic    hit_p1, blk_p1, hit_p2, blk_p2;
  victim_t v_p1, v_p2, v_p1_nxt, v_p2_nxt;

  // Hit beats block; a block landing during hitstun only raises the event.
  function automatic victim_t victim_next(victim_t cur, logic hit, logic blk, logic tick);
    victim_t n;
    n = cur;
    if (hit) begin
      n.st  = HITSTUN;
      n.cnt = HIT_LD;
    end else if (blk) begin
      if (cur.st != HITSTUN) begin
        n.st  = BLOCKSTUN;
        n.cnt = BLK_LD;
      end
    end else if (tick && cur.st != IDLE) begin
      n.cnt = cur.cnt - 1'b1;
      if (cur.cnt == CNT_W'(1)) n.st = IDLE;
    end
    return n;
  endfunction

  always_comb begin
    armed_eff_p1 = armed_p1 | attack_start_p1;
    armed_eff_p2 = armed_p2 | attack_start_p2;
    hit_p2 = frame_tick & got_hit_p2 & armed_eff_p1;
    blk_p2 = frame_tick & got_blocked_p2 & armed_eff_p1 & ~got_hit_p2;
    hit_p1 = frame_tick & got_hit_p1 & armed_eff_p2;
    blk_p1 = frame_tick & got_blocked_p1 & armed_eff_p2 & ~got_hit_p1;
    v_p1_nxt = victim_next(v_p1, hit_p1, blk_p1, frame_tick);
    v_p2_nxt = victim_next(v_p2, hit_p2, blk_p2, frame_tick);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_p1 <= '0;
      v_p2 <= '0;
    end else begin
      v_p1 <= v_p1_nxt;
      v_p2 <= v_p2_nxt;
    end
  end

  // A connection disarms its attacker even when the start arrived on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_p1     <= 1'b0;
      armed_p2     <= 1'b0;
      hit_evt_p1   <= 1'b0;
      block_evt_p1 <= 1'b0;
      hit_evt_p2   <= 1'b0;
      block_evt_p2 <= 1'b0;
      trade_evt    <= 1'b0;
    end else begin
      if (hit_p2 | blk_p2)      armed_p1 <= 1'b0;
      else if (attack_start_p1) armed_p1 <= 1'b1;
      if (hit_p1 | blk_p1)      armed_p2 <= 1'b0;
      else if (attack_start_p2) armed_p2 <= 1'b1;
      hit_evt_p1   <= hit_p1;
      block_evt_p1 <= blk_p1;
      hit_evt_p2   <= hit_p2;
      block_evt_p2 <= blk_p2;
      trade_evt    <= hit_p1 & hit_p2;
    end
  end

  assign hitbox_enable_p1 = armed_p1;
  assign hitbox_enable_p2 = armed_p2;
  assign in_hitstun_p1    = (v_p1.st == HITSTUN);
  assign in_blockstun_p1  = (v_p1.st == BLOCKSTUN);
  assign in_hitstun_p2    = (v_p2.st == HITSTUN);
  assign in_blockstun_p2  = (v_p2.st == BLOCKSTUN);
  assign stun_cnt_p1      = v_p1.cnt;
  assign stun_cnt_p2      = v_p2.cnt;

endmodule
